// File: rtl/dma_ch_mux.sv
// Arbitrated, registered N-channel DMA beat mux with a valid/ready output stage.
// Optional macro DMA_MUX_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module dma_ch_mux #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned CH_NUM = 4,
    localparam int unsigned CHW   = $clog2(CH_NUM)
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic [CH_NUM-1:0]       ch_req,
    input  logic [CH_NUM*WIDTH-1:0] ch_data,
    input  logic [CH_NUM-1:0]       ch_last,
    output logic [CH_NUM-1:0]       ch_ack,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [CHW-1:0]          out_ch,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic                    busy
);

    typedef enum logic {StIdle, StGrant} state_t;

    state_t         state;
    logic [CHW-1:0] g;
    logic [CHW-1:0] ptr;
    logic [CHW-1:0] sel;
    logic           load;

    // Next channel to grant when leaving IDLE.
    always_comb begin
        sel = '0;
`ifdef DMA_MUX_FIXED_PRIO_EN
        for (int i = int'(CH_NUM) - 1; i >= 0; i--) begin
            if (ch_req[i]) sel = CHW'(i);
        end
`else
        begin
            logic        found;
            int unsigned idx;
            found = 1'b0;
            for (int unsigned k = 1; k <= CH_NUM; k++) begin
                idx = (32'(ptr) + k) % CH_NUM;
                if (!found && ch_req[idx]) begin
                    sel   = CHW'(idx);
                    found = 1'b1;
                end
            end
        end
`endif
    end

    // Acks are combinational so a ready downstream sustains one beat per cycle.
    always_comb begin
        load = !HRESET && (state == StGrant) && ch_req[g] && (!out_valid || out_ready);
        ch_ack = '0;
        ch_ack[g] = load;
    end

    assign busy = (state == StGrant) || out_valid;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= StIdle;
            g         <= '0;
            ptr       <= CHW'(CH_NUM - 1);
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (|ch_req) begin
                        g     <= sel;
                        state <= StGrant;
                    end
                end
                StGrant: begin
                    if (load && ch_last[g]) begin
`ifndef DMA_MUX_FIXED_PRIO_EN
                        ptr <= g;
`endif
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase

            if (load) begin
                out_data  <= ch_data[g*WIDTH +: WIDTH];
                out_ch    <= g;
                out_last  <= ch_last[g];
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dma_ch_mux.sv
// Randomised bench for dma_ch_mux against a queue-free behavioural model, plus directed literal checks.
module tb_dma_ch_mux;
    localparam int W  = 32;
    localparam int N  = 4;
    localparam int CW = 2;

    logic              HCLK = 1'b0;
    logic              HRESET;
    logic [N-1:0]      ch_req;
    logic [N*W-1:0]    ch_data;
    logic [N-1:0]      ch_last;
    logic [N-1:0]      ch_ack;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic [CW-1:0]     out_ch;
    logic              out_last;
    logic              out_ready;
    logic              busy;

    dma_ch_mux #(.WIDTH(W), .CH_NUM(N)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .ch_req(ch_req), .ch_data(ch_data),
        .ch_last(ch_last), .ch_ack(ch_ack), .out_valid(out_valid), .out_data(out_data),
        .out_ch(out_ch), .out_last(out_last), .out_ready(out_ready), .busy(busy)
    );

    always #5 HCLK = ~HCLK;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // Model: granted channel (-1 = no burst in progress), last served channel, output slot.
    int          m_grant = -1;
    int          m_ptr = N - 1;
    bit          m_v = 1'b0;
    logic [W-1:0] m_d = '0;
    int          m_c = 0;
    bit          m_l = 1'b0;

    function automatic int pick();
`ifdef DMA_MUX_FIXED_PRIO_EN
        for (int k = 0; k < N; k++) if (ch_req[k]) return k;
`else
        for (int k = 1; k <= N; k++) if (ch_req[(m_ptr + k) % N]) return (m_ptr + k) % N;
`endif
        return -1;
    endfunction

    function automatic bit exp_load();
        return !HRESET && m_grant >= 0 && ch_req[m_grant] && (!m_v || out_ready);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(posedge HCLK) begin
        bit ld;
        ld = exp_load();
        if (HRESET) begin
            m_grant = -1; m_ptr = N - 1; m_v = 1'b0; m_d = '0; m_c = 0; m_l = 1'b0;
        end else if (ld) begin
            m_d = ch_data[m_grant*W +: W];
            m_c = m_grant;
            m_l = ch_last[m_grant];
            m_v = 1'b1;
            if (m_l) begin
`ifndef DMA_MUX_FIXED_PRIO_EN
                m_ptr = m_grant;
`endif
                m_grant = -1;
            end
        end else begin
            if (m_v && out_ready) m_v = 1'b0;
            if (m_grant < 0 && |ch_req) m_grant = pick();
        end
    end

    always @(negedge HCLK) begin
        if (chk_en) begin
            logic [N-1:0] ea;
            ea = '0;
            if (exp_load()) ea[m_grant] = 1'b1;
            chk("ch_ack", 64'(ch_ack), 64'(ea));
            chk("out_valid", 64'(out_valid), 64'(m_v));
            chk("out_data", 64'(out_data), 64'(m_d));
            chk("out_ch", 64'(out_ch), 64'(m_c));
            chk("out_last", 64'(out_last), 64'(m_l));
            chk("busy", 64'(busy), 64'(m_grant >= 0 || m_v));
        end
    end

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        int exp_order [5];
        HRESET = 1'b1; ch_req = '0; ch_last = '0; ch_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        chk_en = 1'b1;

        // Three-beat burst on channel 0.
        ch_req = 4'b0001; ch_data[0 +: W] = 32'hA0; ch_last = '0;
        @(negedge HCLK);
        chk("lit_reset_ack", 64'(ch_ack), 64'h0);
        chk("lit_reset_valid", 64'(out_valid), 64'h0);
        chk("lit_reset_busy", 64'(busy), 64'h0);
        step();
        @(negedge HCLK);
        chk("lit_ack0", 64'(ch_ack), 64'h1);
        chk("lit_valid0", 64'(out_valid), 64'h0);
        step(); ch_data[0 +: W] = 32'hA1;
        @(negedge HCLK);
        chk("lit_ack1", 64'(ch_ack), 64'h1);
        chk("lit_data_a0", 64'(out_data), 64'hA0);
        chk("lit_last_a0", 64'(out_last), 64'h0);
        step(); ch_data[0 +: W] = 32'hA2; ch_last = 4'b0001;
        @(negedge HCLK);
        chk("lit_data_a1", 64'(out_data), 64'hA1);
        step(); ch_req = '0; ch_last = '0;
        @(negedge HCLK);
        chk("lit_data_a2", 64'(out_data), 64'hA2);
        chk("lit_last_a2", 64'(out_last), 64'h1);
        chk("lit_ch_a2", 64'(out_ch), 64'h0);
        chk("lit_ack_idle", 64'(ch_ack), 64'h0);
        chk("lit_busy_tail", 64'(busy), 64'h1);
        step();
        @(negedge HCLK);
        chk("lit_busy_done", 64'(busy), 64'h0);

        // All channels with single-beat bursts: grant order after reset.
`ifdef DMA_MUX_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        step(); HRESET = 1'b1;
        step(); HRESET = 1'b0; ch_req = '1; ch_last = '1;
        for (int k = 0; k < N; k++) ch_data[k*W +: W] = 32'hB0 + k;
        for (int t = 0; t <= 10; t++) begin
            if (t > 0) step();
            @(negedge HCLK);
            if (t >= 2 && t % 2 == 0) begin
                chk("lit_rr_order", 64'(out_ch), 64'(exp_order[(t-2)/2]));
                chk("lit_rr_valid", 64'(out_valid), 64'h1);
            end
        end

        // Random traffic, stalls and occasional mid-burst resets.
        for (int c = 0; c < 4000; c++) begin
            step();
            HRESET    = ($urandom_range(0, 99) == 0);
            ch_req    = N'($urandom);
            ch_last   = '0;
            for (int k = 0; k < N; k++) begin
                ch_data[k*W +: W] = $urandom;
                ch_last[k] = ($urandom_range(0, 3) == 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        step();
        @(negedge HCLK);
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dma_ch_mux.md
# dma_ch_mux

Parametrised N-channel data multiplexer for the AHB DMA datapath, generalising the fixed two-input select into an arbitrated, registered channel mux. Each DMA channel presents beats with a request/last flag; the block grants one channel at a time in round-robin order, holds the grant for a whole burst, and forwards beats through a single output register with a valid/ready handshake towards the AHB master interface.

## Interface
- WIDTH, 32, data width of each channel beat
- CH_NUM, 4, number of channels (2..8); CHW = $clog2(CH_NUM)

- HCLK  in  1  block clock
- HRESET  in  1  reset; one clock; reset is synchronous and active-high
- ch_req  in  CH_NUM  per-channel beat available
- ch_data  in  CH_NUM*WIDTH  packed beats, channel i at [i*WIDTH +: WIDTH]
- ch_last  in  CH_NUM  beat is last of channel's burst
- ch_ack  out  CH_NUM  one-hot, beat of that channel accepted this cycle
- out_valid  out  1  output register holds a beat
- out_data  out  WIDTH  registered beat
- out_ch  out  CHW  channel index of registered beat
- out_last  out  1  registered beat is last of burst
- out_ready  in  1  downstream accepts beat
- busy  out  1  grant active or output register full

## Operation
- FSM states IDLE, GRANT; grant index g (CHW bits), round-robin pointer ptr (last served channel).
- IDLE: if any ch_req, select first requesting channel searching ptr+1, ptr+2, … modulo CH_NUM; latch g, go GRANT. No ack in IDLE. No request: stay IDLE.
- GRANT: load = ch_req[g] && (!out_valid || out_ready). ch_ack[g] = load (combinational, depends on out_ready); all other ch_ack bits 0.
- On load: out_data <= ch_data[g], out_ch <= g, out_last <= ch_last[g], out_valid <= 1.
- Output drain without load (out_valid && out_ready && !load): out_valid <= 0.
- Load with ch_last[g]=1: ptr <= g, FSM -> IDLE next cycle.
- ch_req[g] low in GRANT: grant held, no ack, no timeout; requests from other channels ignored until burst ends.
- busy = (state==GRANT) || out_valid.

## Timing
- Reset values: state IDLE, ptr = CH_NUM-1 (channel 0 served first), out_valid 0, out_data 0, out_ch 0, out_last 0, ch_ack 0, busy 0.
- Arbitration latency: request seen in IDLE at cycle n -> first ch_ack earliest cycle n+1, out_valid cycle n+2.
- Beat latency: ack cycle -> out_valid next cycle; sustained throughput 1 beat/cycle with out_ready held high.
- Burst-to-burst gap: exactly one IDLE cycle between last ack of one burst and first ack of the next; output register may drain during that cycle.
- out_valid && !out_ready: out_data, out_ch, out_last held stable; no ack issued.
- Single-beat burst (ch_last on first beat) valid: GRANT lasts one cycle.
- HRESET mid-burst: all state cleared next edge, in-flight beat in output register discarded, no ack in the reset cycle.

## Configuration
- DMA_MUX_FIXED_PRIO_EN: when defined, IDLE arbitration selects lowest-index requesting channel; ptr is not used (still reset but never updated). When undefined, round-robin as above. All other behaviour identical.

## Test plan
- Reset, then ch_req=4'b0001, 3-beat burst 0xA0,0xA1,0xA2 (last on third), out_ready=1 -> acks cycles 2..4, out_data A0,A1,A2 cycles 3..5 with out_ch=0, out_last only on A2, busy falls cycle 6.
- All four channels request continuous single-beat bursts -> grant order 0,1,2,3,0 (round-robin); with DMA_MUX_FIXED_PRIO_EN -> 0,0,0,… while ch_req[0] high.
- Channel 1 burst, out_ready low for 3 cycles after first beat -> out_data stable, ch_ack 0 during stall, no beat lost or duplicated.
- Channel 2 deasserts ch_req mid-burst while channel 3 requests -> grant stays on 2, channel 3 gets no ack until channel 2 sends last beat.
- HRESET asserted with out_valid=1 mid-burst -> next cycle all outputs at reset values; subsequent arbitration starts at channel 0.
- CH_NUM=3, ptr=2, channels 0 and 2 request -> channel 0 granted (wrap-around).
